key_fetch_initiator: RTL and testbench

- Requesting (read-side) end of the key-store word interface.
- On a start pulse it fetches a multi-word key from a selected key-store slot one word at a time using a req/ack handshake, with per-word timeout and bounded retry.
- It assembles the words in a private shadow register and hands the full key to the crypto datapath with a valid/consume handshake.
- It zeroizes the shadow on consume, abort or error; the key is never visible on the output while not valid.

---
 rtl/key_fetch_initiator_if.sv | 33 +++
 rtl/key_fetch_initiator.sv | 124 ++++++++++++
 tb/tb_key_fetch_initiator.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_fetch_initiator_if.sv
// Bundle of start/key-store/consumer signals seen by the key fetch initiator.
// master = the initiator; slave = the environment (key store plus consumer).
interface key_fetch_initiator_if #(
    parameter int unsigned WORDS  = 4,
    parameter int unsigned DATA_W = 32
) ();
    localparam int unsigned WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic                      start;
    logic [1:0]                slot;
    logic                      abort;
    logic                      busy;
    logic                      ks_req;
    logic [1:0]                ks_slot;
    logic [WORD_W-1:0]         ks_word;
    logic                      ks_ack;
    logic                      ks_err;
    logic [DATA_W-1:0]         ks_rdata;
    logic [WORDS*DATA_W-1:0]   key_out;
    logic                      key_valid;
    logic                      key_consume;
    logic                      fetch_err;

    modport master (
        input  start, slot, abort, ks_ack, ks_err, ks_rdata, key_consume,
        output busy, ks_req, ks_slot, ks_word, key_out, key_valid, fetch_err
    );

    modport slave (
        output start, slot, abort, ks_ack, ks_err, ks_rdata, key_consume,
        input  busy, ks_req, ks_slot, ks_word, key_out, key_valid, fetch_err
    );
endinterface

// File: rtl/key_fetch_initiator.sv
// Fetches a multi-word key from a key-store slot word by word (req/ack, timeout, retry),
// assembles it in a private shadow and presents it to the consumer with valid/consume.
module key_fetch_initiator #(
    parameter int unsigned WORDS     = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT   = 15,
    parameter int unsigned MAX_RETRY = 2
) (
    input logic                   clk,
    input logic                   rst,
    key_fetch_initiator_if.master bus
);
    localparam int unsigned WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StErr} state_e;

    state_e                        state_q, state_d;
    logic [1:0]                    slot_q, slot_d;
    logic [WORD_W-1:0]             word_q, word_d;
    logic [RTY_W-1:0]              retry_q, retry_d;
    logic [TMR_W-1:0]              timer_q, timer_d;
    logic [WORDS-1:0][DATA_W-1:0]  shadow_q, shadow_d;
    logic                          err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            slot_q   <= '0;
            word_q   <= '0;
            retry_q  <= '0;
            timer_q  <= '0;
            shadow_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            word_q   <= word_d;
            retry_q  <= retry_d;
            timer_q  <= timer_d;
            shadow_q <= shadow_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        word_d   = word_q;
        retry_d  = retry_q;
        timer_d  = timer_q;
        shadow_d = shadow_q;
        err_d    = err_q;

        if (bus.abort) begin
            state_d  = StIdle;
            shadow_d = '0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                StIdle, StErr: begin
                    if (bus.start) begin
                        slot_d  = bus.slot;
                        word_d  = '0;
                        retry_d = '0;
                        err_d   = 1'b0;
                        state_d = StReq;
                    end
                end
                StReq: begin
                    timer_d = '0;
                    state_d = StWait;
                end
                StWait: begin
                    // A good ack takes precedence over a timeout in the same cycle.
                    if (bus.ks_ack && !bus.ks_err) begin
                        shadow_d[word_q] = bus.ks_rdata;
                        retry_d          = '0;
                        if (word_q == LAST_WORD) begin
                            state_d = StHold;
                        end else begin
                            word_d  = word_q + 1'b1;
                            state_d = StReq;
                        end
                    end else if (bus.ks_ack || (timer_q == TMR_LAST)) begin
                        if (retry_q < RTY_MAX) begin
                            retry_d = retry_q + 1'b1;
                            state_d = StReq;
                        end else begin
                            shadow_d = '0;
                            err_d    = 1'b1;
                            state_d  = StErr;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                StHold: begin
                    if (bus.key_consume) begin
                        shadow_d = '0;
                        state_d  = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    logic req;
    assign req           = (state_q == StReq) && !bus.abort;
    assign bus.busy      = (state_q == StReq) || (state_q == StWait);
    assign bus.ks_req    = req;
    assign bus.ks_slot   = req ? slot_q : 2'b00;
    assign bus.ks_word   = req ? word_q : '0;
    assign bus.key_valid = (state_q == StHold);
    // Partially assembled words never leave the block.
    assign bus.key_out   = (state_q == StHold) ? shadow_q : '0;
    assign bus.fetch_err = err_q;
endmodule

// File: tb/tb_key_fetch_initiator.sv
// Bench for key_fetch_initiator: directed scenarios plus random traffic, all outputs
// checked every cycle against a transaction-level model of the fetch protocol.
module tb_key_fetch_initiator;
    localparam int unsigned WORDS     = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned TIMEOUT   = 15;
    localparam int unsigned MAX_RETRY = 2;
    localparam int unsigned KW        = WORDS * DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    key_fetch_initiator_if #(.WORDS(WORDS), .DATA_W(DATA_W)) bus ();

    key_fetch_initiator #(
        .WORDS    (WORDS),
        .DATA_W   (DATA_W),
        .TIMEOUT  (TIMEOUT),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [KW-1:0] act, input logic [KW-1:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp_v);
        end
    endtask

    // ---------------- reference model ----------------
    bit               m_ready = 1'b0;
    logic             m_busy, m_req, m_valid, m_err;
    logic [1:0]       m_slot;
    int               m_word;
    logic [KW-1:0]    m_key;

    task automatic m_quiet();
        m_busy = 1'b0; m_req = 1'b0; m_valid = 1'b0; m_key = '0; m_word = 0;
    endtask

    task automatic m_kill();
        m_err = 1'b0;
        m_quiet();
    endtask

    // One fetch as a sequence of word transactions; returns on done/abort/reset/error.
    task automatic run_fetch();
        logic [DATA_W-1:0] sh [WORDS];
        int tries, waited;
        bit got, failed;
        for (int w = 0; w < WORDS; w++) begin
            tries = 0;
            got   = 1'b0;
            while (!got) begin
                m_busy = 1'b1; m_req = 1'b1; m_word = w;
                @(posedge clk);
                if (rst || bus.abort) begin m_kill(); return; end
                m_req  = 1'b0;
                waited = 0;
                failed = 1'b0;
                while (!got && !failed) begin
                    @(posedge clk);
                    if (rst || bus.abort) begin m_kill(); return; end
                    waited++;
                    if (bus.ks_ack && !bus.ks_err) begin
                        sh[w] = bus.ks_rdata;
                        got   = 1'b1;
                    end else if (bus.ks_ack || waited == int'(TIMEOUT)) begin
                        failed = 1'b1;
                    end
                end
                if (failed) begin
                    tries++;
                    if (tries > int'(MAX_RETRY)) begin
                        m_err = 1'b1;
                        m_quiet();
                        return;
                    end
                end
            end
        end
        m_busy  = 1'b0;
        m_valid = 1'b1;
        for (int w = 0; w < WORDS; w++) m_key[w*DATA_W +: DATA_W] = sh[w];
        forever begin
            @(posedge clk);
            if (rst || bus.abort) begin m_kill(); return; end
            if (bus.key_consume) begin m_quiet(); return; end
        end
    endtask

    initial begin : model
        m_err = 1'b0;
        m_slot = 2'b00;
        m_quiet();
        forever begin
            @(posedge clk);
            if (rst || bus.abort) begin
                if (rst) m_ready = 1'b1;
                m_kill();
            end else if (m_ready && bus.start) begin
                m_err  = 1'b0;
                m_slot = bus.slot;
                run_fetch();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        logic exp_req;
        if (m_ready) begin
            exp_req = m_req && !bus.abort;
            chk("busy", KW'(bus.busy), KW'(m_busy));
            chk("ks_req", KW'(bus.ks_req), KW'(exp_req));
            chk("ks_slot", KW'(bus.ks_slot), KW'(exp_req ? m_slot : 2'b00));
            chk("ks_word", KW'(bus.ks_word), KW'(exp_req ? 2'(m_word) : 2'b00));
            chk("key_valid", KW'(bus.key_valid), KW'(m_valid));
            chk("key_out", bus.key_out, m_key);
            chk("fetch_err", KW'(bus.fetch_err), KW'(m_err));
        end
    end

    // ---------------- request log ----------------
    int req_cyc[$];
    int req_word[$];
    int req_slot[$];
    always @(negedge clk) begin
        if (bus.ks_req === 1'b1) begin
            req_cyc.push_back(cyc);
            req_word.push_back(int'(bus.ks_word));
            req_slot.push_back(int'(bus.ks_slot));
        end
    end

    task automatic req_clear();
        req_cyc.delete(); req_word.delete(); req_slot.delete();
    endtask

    // ---------------- key-store responder ----------------
    typedef struct {
        int                dly;
        bit                err;
        bit                drop;
        logic [DATA_W-1:0] data;
    } rsp_t;
    rsp_t plan[$];

    task automatic push(input int dly, input bit err, input bit drop, input logic [DATA_W-1:0] d);
        rsp_t r;
        r.dly = dly; r.err = err; r.drop = drop; r.data = d;
        plan.push_back(r);
    endtask

    task automatic push_ok(output logic [KW-1:0] k);
        logic [DATA_W-1:0] d;
        k = '0;
        for (int i = 0; i < WORDS; i++) begin
            d = $urandom;
            push(1, 1'b0, 1'b0, d);
            k[i*DATA_W +: DATA_W] = d;
        end
    endtask

    initial begin : responder
        rsp_t r;
        bus.ks_ack = 1'b0; bus.ks_err = 1'b0; bus.ks_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.ks_req === 1'b1) begin
                if (plan.size() > 0) begin
                    r = plan.pop_front();
                end else begin
                    r.drop = ($urandom_range(0, 7) == 0);
                    r.err  = ($urandom_range(0, 5) == 0);
                    r.dly  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TIMEOUT))
                                                          : int'($urandom_range(1, 3));
                    r.data = $urandom;
                end
                if (!r.drop) begin
                    repeat (r.dly) @(posedge clk);
                    #1;
                    bus.ks_ack = 1'b1; bus.ks_err = r.err; bus.ks_rdata = r.data;
                    @(posedge clk);
                    #1;
                    bus.ks_ack = 1'b0; bus.ks_err = 1'b0; bus.ks_rdata = $urandom;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_start(input logic [1:0] s, output int c0);
        bus.start = 1'b1; bus.slot = s;
        step(1);
        c0 = cyc;
        bus.start = 1'b0;
    endtask

    // which: 0 = key_valid, 1 = fetch_err
    task automatic wait_sig(input int which, input int lim, input string nm);
        int n = 0;
        while (((which == 0) ? bus.key_valid : bus.fetch_err) !== 1'b1 && n < lim) begin
            step(1);
            n++;
        end
        chk(nm, KW'((which == 0) ? bus.key_valid : bus.fetch_err), KW'(1'b1));
    endtask

    task automatic pulse_consume(input string nm);
        bus.key_consume = 1'b1; step(1); bus.key_consume = 1'b0;
        chk({nm, " valid drop"}, KW'(bus.key_valid), KW'(1'b0));
        chk({nm, " key zero"}, bus.key_out, KW'(0));
    endtask

    task automatic pulse_abort();
        bus.abort = 1'b1; step(1); bus.abort = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int c0, n;
        logic [KW-1:0] exp_key;
        logic [DATA_W-1:0] d0, d1, d2, d3;
        bus.start = 1'b0; bus.slot = 2'b00; bus.abort = 1'b0; bus.key_consume = 1'b0;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        chk("reset busy", KW'(bus.busy), KW'(0));
        chk("reset ks_req", KW'(bus.ks_req), KW'(0));
        chk("reset key_valid", KW'(bus.key_valid), KW'(0));
        chk("reset key_out", bus.key_out, KW'(0));
        chk("reset fetch_err", KW'(bus.fetch_err), KW'(0));

        // Normal fetch, slot 2, one-cycle acks.
        req_clear();
        push(1, 1'b0, 1'b0, 32'h11111111);
        push(1, 1'b0, 1'b0, 32'h22222222);
        push(1, 1'b0, 1'b0, 32'h33333333);
        push(1, 1'b0, 1'b0, 32'h44444444);
        do_start(2'd2, c0);
        wait_sig(0, 40, "normal key_valid");
        chk("normal latency", KW'(cyc - c0), KW'(8));
        chk("normal key", bus.key_out, 128'h44444444_33333333_22222222_11111111);
        n = 0;
        foreach (req_word[i]) n = n * 16 + req_word[i] * 4 + req_slot[i];
        chk("normal req sequence", KW'(n), KW'(32'h26AE));

        // Start while holding is ignored.
        req_clear();
        bus.start = 1'b1; step(1); bus.start = 1'b0;
        step(2);
        chk("hold start reqs", KW'(req_cyc.size()), KW'(0));
        chk("hold start valid", KW'(bus.key_valid), KW'(1));
        pulse_consume("consume");
        chk("consume busy", KW'(bus.busy), KW'(0));

        // Second slot after consume fetches fresh data.
        push_ok(exp_key);
        do_start(2'd1, c0);
        wait_sig(0, 40, "second key_valid");
        chk("second key", bus.key_out, exp_key);
        pulse_consume("second consume");

        // Word 1 refused twice, then accepted.
        req_clear();
        d0 = $urandom; d1 = $urandom; d2 = $urandom; d3 = $urandom;
        push(1, 1'b0, 1'b0, d0);
        push(1, 1'b1, 1'b0, 32'hBAD0BAD0);
        push(2, 1'b1, 1'b0, 32'hBAD1BAD1);
        push(1, 1'b0, 1'b0, d1);
        push(1, 1'b0, 1'b0, d2);
        push(1, 1'b0, 1'b0, d3);
        do_start(2'd3, c0);
        wait_sig(0, 60, "retry key_valid");
        n = 0;
        foreach (req_word[i]) if (req_word[i] == 1) n++;
        chk("retry word1 reqs", KW'(n), KW'(3));
        chk("retry fetch_err", KW'(bus.fetch_err), KW'(0));
        chk("retry key", bus.key_out, {d3, d2, d1, d0});
        pulse_consume("retry consume");

        // Word 0 never acknowledged: three attempts then sticky error.
        req_clear();
        push(1, 1'b0, 1'b1, '0);
        push(1, 1'b0, 1'b1, '0);
        push(1, 1'b0, 1'b1, '0);
        do_start(2'd0, c0);
        wait_sig(1, 100, "timeout fetch_err");
        chk("timeout req count", KW'(req_cyc.size()), KW'(3));
        if (req_cyc.size() >= 3) begin
            chk("timeout spacing 1", KW'(req_cyc[1] - req_cyc[0]), KW'(TIMEOUT + 1));
            chk("timeout spacing 2", KW'(req_cyc[2] - req_cyc[1]), KW'(TIMEOUT + 1));
        end
        step(5);
        chk("timeout sticky", KW'(bus.fetch_err), KW'(1));
        chk("timeout key_out", bus.key_out, KW'(0));
        req_clear();
        push_ok(exp_key);
        do_start(2'd1, c0);
        chk("restart clears err", KW'(bus.fetch_err), KW'(0));
        wait_sig(0, 40, "restart key_valid");
        chk("restart first word", KW'(req_word.size() > 0 ? req_word[0] : -1), KW'(0));
        chk("restart key", bus.key_out, exp_key);
        pulse_consume("restart consume");

        // Abort after two words; the late ack for word 2 must be ignored.
        req_clear();
        push(1, 1'b0, 1'b0, $urandom);
        push(1, 1'b0, 1'b0, $urandom);
        push(3, 1'b0, 1'b0, 32'hDEADBEEF);
        do_start(2'd2, c0);
        step(5);
        pulse_abort();
        chk("abort busy", KW'(bus.busy), KW'(0));
        step(4);
        chk("abort late ack busy", KW'(bus.busy), KW'(0));
        chk("abort late ack valid", KW'(bus.key_valid), KW'(0));
        chk("abort late ack key", bus.key_out, KW'(0));
        chk("abort req count", KW'(req_cyc.size()), KW'(3));

        // Abort in hold, then a refused fetch shows nothing stale.
        push_ok(exp_key);
        do_start(2'd0, c0);
        wait_sig(0, 40, "abort-hold key_valid");
        pulse_abort();
        chk("abort hold valid", KW'(bus.key_valid), KW'(0));
        chk("abort hold key", bus.key_out, KW'(0));
        push(1, 1'b1, 1'b0, $urandom);
        push(1, 1'b1, 1'b0, $urandom);
        push(1, 1'b1, 1'b0, $urandom);
        do_start(2'd3, c0);
        wait_sig(1, 40, "refused fetch_err");
        chk("refused key", bus.key_out, KW'(0));
        pulse_abort();
        chk("abort clears err", KW'(bus.fetch_err), KW'(0));

        // Ack on the last wait cycle wins over timeout.
        req_clear();
        d0 = $urandom;
        push(TIMEOUT, 1'b0, 1'b0, d0);
        push(1, 1'b0, 1'b0, 32'h0000AAAA);
        push(1, 1'b0, 1'b0, 32'h0000BBBB);
        push(1, 1'b0, 1'b0, 32'h0000CCCC);
        do_start(2'd1, c0);
        wait_sig(0, 60, "edge key_valid");
        chk("edge req count", KW'(req_cyc.size()), KW'(WORDS));
        chk("edge key", bus.key_out, {32'h0000CCCC, 32'h0000BBBB, 32'h0000AAAA, d0});

        // Reset while holding.
        rst = 1'b1; step(1); rst = 1'b0;
        chk("rst hold valid", KW'(bus.key_valid), KW'(0));
        chk("rst hold key", bus.key_out, KW'(0));
        chk("rst hold busy", KW'(bus.busy), KW'(0));
        chk("rst hold err", KW'(bus.fetch_err), KW'(0));

        // Random traffic against the model.
        plan.delete();
        for (int i = 0; i < 4000; i++) begin
            bus.start       = ($urandom_range(0, 3) == 0);
            bus.slot        = 2'($urandom_range(0, 3));
            bus.abort       = ($urandom_range(0, 59) == 0);
            bus.key_consume = ($urandom_range(0, 2) == 0);
            rst             = ($urandom_range(0, 799) == 0);
            step(1);
        end
        bus.start = 1'b0; bus.abort = 1'b0; bus.key_consume = 1'b0; rst = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
